// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed address/data bus sequencer.
// One request per transaction: address phase, data phase, one-cycle fin.
module rtc_bus_sequencer #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int CW      = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] dir,
  input  logic [7:0] dato_wr,
  output logic [7:0] dato_rd,
  output logic       fin,
  output logic       busy,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_n,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  input  logic [7:0] AD_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASET,
    S_APUL,
    S_AHLD,
    S_DSET,
    S_DPUL,
    S_DHLD,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] LD_S = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_P = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_H = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [7:0]    dir_q, dir_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    rdat_q, rdat_d;
  logic          last;

  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_n_q, ad_n_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;
  logic       fin_q, fin_d;
  logic       busy_q, busy_d;

  assign last = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    dir_d   = dir_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      S_IDLE: begin
        // write has priority when both requests arrive together
        if (start_wr || start_rd) begin
          wr_d    = start_wr;
          dir_d   = dir;
          dat_d   = dato_wr;
          state_d = S_ASET;
          cnt_d   = LD_S;
        end
      end
      S_ASET: begin
        if (last) begin
          state_d = S_APUL;
          cnt_d   = LD_P;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_APUL: begin
        if (last) begin
          state_d = S_AHLD;
          cnt_d   = LD_H;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_AHLD: begin
        if (last) begin
          state_d = S_DSET;
          cnt_d   = LD_S;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DSET: begin
        if (last) begin
          state_d = S_DPUL;
          cnt_d   = LD_P;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DPUL: begin
        if (last) begin
          // sample while RD_n is still low
          if (!wr_q) begin
            rdat_d = AD_in;
          end
          state_d = S_DHLD;
          cnt_d   = LD_H;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DHLD: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state so they register
  // in step with the state they belong to.
  always_comb begin
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    ad_n_d = 1'b1;
    oe_d   = 1'b0;
    out_d  = 8'h00;
    fin_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_ASET, S_APUL, S_AHLD: begin
        cs_n_d = 1'b0;
        ad_n_d = 1'b0;
        oe_d   = 1'b1;
        out_d  = dir_d;
        wr_n_d = (state_d != S_APUL);
      end
      S_DSET, S_DPUL, S_DHLD: begin
        cs_n_d = 1'b0;
        if (wr_d) begin
          oe_d   = 1'b1;
          out_d  = dat_d;
          wr_n_d = (state_d != S_DPUL);
        end else begin
          rd_n_d = (state_d != S_DPUL);
        end
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      dir_q   <= 8'h00;
      dat_q   <= 8'h00;
      rdat_q  <= 8'h00;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ad_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      out_q   <= 8'h00;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ad_n_q  <= ad_n_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign dato_rd = rdat_q;
  assign fin     = fin_q;
  assign busy    = busy_q;
  assign CS_n    = cs_n_q;
  assign RD_n    = rd_n_q;
  assign WR_n    = wr_n_q;
  assign AD_n    = ad_n_q;
  assign AD_out  = out_q;
  assign AD_oe   = oe_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: default timing and a 1/1/1 instance,
// both checked cycle by cycle against a phase-offset waveform model.
module tb_rtc_bus_sequencer;

  typedef struct packed {
    logic       cs;
    logic       rdn;
    logic       wrn;
    logic       adn;
    logic       oe;
    logic [7:0] out;
    logic       fin;
    logic       busy;
  } bus_t;

  logic       CLK = 1'b0;
  logic       reset;
  logic       swr0, srd0, swr1, srd1;
  logic [7:0] dir_t, dat_t;
  logic [7:0] rdv0, rdv1;
  logic [7:0] ad_in0, ad_in1;

  logic [7:0] dato_rd0, dato_rd1, out0, out1;
  logic       fin0, busy0, cs0, rdn0, wrn0, adn0, oe0;
  logic       fin1, busy1, cs1, rdn1, wrn1, adn1, oe1;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rd0, last_rd1;

  always #5 CLK = ~CLK;

  // external chip: drives its register value only while RD_n is low
  assign ad_in0 = rdn0 ? 8'h00 : rdv0;
  assign ad_in1 = rdn1 ? 8'h00 : rdv1;

  rtc_bus_sequencer dut0 (
    .CLK(CLK), .reset(reset),
    .start_wr(swr0), .start_rd(srd0),
    .dir(dir_t), .dato_wr(dat_t),
    .dato_rd(dato_rd0), .fin(fin0), .busy(busy0),
    .CS_n(cs0), .RD_n(rdn0), .WR_n(wrn0), .AD_n(adn0),
    .AD_out(out0), .AD_oe(oe0), .AD_in(ad_in0)
  );

  rtc_bus_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut1 (
    .CLK(CLK), .reset(reset),
    .start_wr(swr1), .start_rd(srd1),
    .dir(dir_t), .dato_wr(dat_t),
    .dato_rd(dato_rd1), .fin(fin1), .busy(busy1),
    .CS_n(cs1), .RD_n(rdn1), .WR_n(wrn1), .AD_n(adn1),
    .AD_out(out1), .AD_oe(oe1), .AD_in(ad_in1)
  );

  function automatic bus_t obs(input bit inst);
    bus_t o;
    if (inst) o = {cs1, rdn1, wrn1, adn1, oe1, out1, fin1, busy1};
    else      o = {cs0, rdn0, wrn0, adn0, oe0, out0, fin0, busy0};
    return o;
  endfunction

  // expected pins j cycles after the accepting edge
  function automatic bus_t exp_at(input int j, input bit w,
                                  input logic [7:0] d, input logic [7:0] dt,
                                  input int s, input int p, input int h);
    bus_t e;
    int   n, k;
    bit   data, pulse;
    e.cs = 1; e.rdn = 1; e.wrn = 1; e.adn = 1;
    e.oe = 0; e.out = 8'h00; e.fin = 0; e.busy = 0;
    n = s + p + h;
    if (j >= 0 && j < 2 * n) begin
      e.busy = 1;
      e.cs   = 0;
      data   = (j >= n);
      k      = data ? j - n : j;
      pulse  = (k >= s) && (k < s + p);
      if (!data) begin
        e.adn = 0; e.oe = 1; e.out = d; e.wrn = !pulse;
      end else if (w) begin
        e.oe = 1; e.out = dt; e.wrn = !pulse;
      end else begin
        e.rdn = !pulse;
      end
    end else if (j == 2 * n) begin
      e.busy = 1;
      e.fin  = 1;
    end
    return e;
  endfunction

  function automatic bus_t idle_v();
    return exp_at(-1, 1'b0, 8'h00, 8'h00, 1, 1, 1);
  endfunction

  // called #1 after an edge; returns #1 after the accepting edge
  task automatic issue(input bit inst, input bit w, input bit r);
    if (inst) begin swr1 = w; srd1 = r; end
    else      begin swr0 = w; srd0 = r; end
    @(posedge CLK); #1;
    swr0 = 0; srd0 = 0; swr1 = 0; srd1 = 0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      checks++;
      if (!rdn0 && !wrn0) begin
        errors++;
        $display("FAIL overlap0 RD_n=%b WR_n=%b required not both 0", rdn0, wrn0);
      end
      checks++;
      if (!rdn1 && !wrn1) begin
        errors++;
        $display("FAIL overlap1 RD_n=%b WR_n=%b required not both 0", rdn1, wrn1);
      end
    end
  end

  task automatic test_reset();
    bus_t g, e;
    reset = 1;
    repeat (2) step();
    g = obs(0);
    checks++;
    if (g !== idle_v() || dato_rd0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got %h/%h exp %h/00", g, dato_rd0, idle_v());
    end
    reset = 0;
    step();
    dir_t = 8'h3c; dat_t = 8'h99;
    issue(0, 1, 0);
    repeat (11) step();
    g = obs(0);
    e = exp_at(11, 1, 8'h3c, 8'h99, 2, 4, 2);
    checks++;
    if (g !== e || wrn0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre got %h exp %h", g, e);
    end
    #2 reset = 1;
    #1;
    g = obs(0);
    checks++;
    if (g !== idle_v()) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", g, idle_v());
    end
    step();
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      g = obs(0);
      checks++;
      if (g !== idle_v()) begin
        errors++;
        $display("FAIL reset_noresume i=%0d got %h exp %h", i, g, idle_v());
      end
      step();
    end
    last_rd0 = 8'h00;
    last_rd1 = 8'h00;
  endtask

  task automatic test_write();
    bus_t g, e;
    logic [7:0] d, t;
    for (int n = 0; n < 5; n++) begin
      d = (n == 0) ? 8'h21 : 8'($urandom);
      t = (n == 0) ? 8'h45 : 8'($urandom);
      dir_t = d; dat_t = t;
      issue(0, 1, 0);
      dir_t = 8'($urandom); dat_t = 8'($urandom);
      for (int j = 0; j <= 17; j++) begin
        g = obs(0);
        e = exp_at(j, 1, d, t, 2, 4, 2);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL write n=%0d j=%0d got %h exp %h", n, j, g, e);
        end
        step();
      end
      checks++;
      if (dato_rd0 !== last_rd0) begin
        errors++;
        $display("FAIL write_keeps_rd got %h exp %h", dato_rd0, last_rd0);
      end
    end
  endtask

  task automatic test_read();
    bus_t g, e;
    logic [7:0] d;
    for (int n = 0; n < 5; n++) begin
      d    = (n == 0) ? 8'h23 : 8'($urandom);
      rdv0 = (n == 0) ? 8'h59 : 8'($urandom);
      dir_t = d; dat_t = 8'($urandom);
      issue(0, 0, 1);
      for (int j = 0; j <= 17; j++) begin
        g = obs(0);
        e = exp_at(j, 0, d, 8'h00, 2, 4, 2);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL read n=%0d j=%0d got %h exp %h", n, j, g, e);
        end
        step();
      end
      last_rd0 = rdv0;
      checks++;
      if (dato_rd0 !== last_rd0) begin
        errors++;
        $display("FAIL read_data n=%0d got %h exp %h", n, dato_rd0, last_rd0);
      end
    end
  endtask

  task automatic test_both();
    bus_t g, e;
    dir_t = 8'h5a; dat_t = 8'ha5; rdv0 = 8'h77;
    issue(0, 1, 1);
    for (int j = 0; j <= 19; j++) begin
      g = obs(0);
      e = exp_at(j, 1, 8'h5a, 8'ha5, 2, 4, 2);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL both j=%0d got %h exp %h", j, g, e);
      end
      step();
    end
    checks++;
    if (dato_rd0 !== last_rd0) begin
      errors++;
      $display("FAIL both_rd got %h exp %h", dato_rd0, last_rd0);
    end
  endtask

  task automatic test_back_to_back();
    bus_t g, e;
    logic [7:0] wd, wt, rd;
    wd = 8'($urandom); wt = 8'($urandom); rd = 8'($urandom);
    rdv0 = 8'($urandom);
    dir_t = wd; dat_t = wt;
    issue(0, 1, 0);
    for (int j = 0; j <= 17; j++) begin
      g = obs(0);
      e = exp_at(j, 1, wd, wt, 2, 4, 2);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL busy_ignore j=%0d got %h exp %h", j, g, e);
      end
      srd0 = (j == 5) || (j == 16) || (j == 17);
      if (j == 17) dir_t = rd;
      step();
    end
    srd0 = 0;
    for (int j = 0; j <= 17; j++) begin
      g = obs(0);
      e = exp_at(j, 0, rd, 8'h00, 2, 4, 2);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_read j=%0d got %h exp %h", j, g, e);
      end
      step();
    end
    last_rd0 = rdv0;
    checks++;
    if (dato_rd0 !== last_rd0) begin
      errors++;
      $display("FAIL b2b_data got %h exp %h", dato_rd0, last_rd0);
    end
  endtask

  task automatic test_fast();
    bus_t g, e;
    logic [7:0] d, t;
    bit w;
    for (int n = 0; n < 8; n++) begin
      w = (n < 2) ? n[0] : 1'($urandom);
      d = 8'($urandom); t = 8'($urandom);
      rdv1 = 8'($urandom);
      dir_t = d; dat_t = t;
      issue(1, w, !w);
      for (int j = 0; j <= 7; j++) begin
        g = obs(1);
        e = exp_at(j, w, d, t, 1, 1, 1);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL fast n=%0d j=%0d got %h exp %h", n, j, g, e);
        end
        step();
      end
      if (!w) last_rd1 = rdv1;
      checks++;
      if (dato_rd1 !== last_rd1) begin
        errors++;
        $display("FAIL fast_rd n=%0d got %h exp %h", n, dato_rd1, last_rd1);
      end
    end
  endtask

  initial begin
    reset = 1;
    swr0 = 0; srd0 = 0; swr1 = 0; srd1 = 0;
    dir_t = 8'h00; dat_t = 8'h00;
    rdv0 = 8'h00; rdv1 = 8'h00;
    last_rd0 = 8'h00; last_rd1 = 8'h00;
    #1;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_back_to_back();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
